vga_axil_slave: RTL and testbench
=================================

Name: vga_axil_slave

Overview:
AXI4-Lite slave front end for the VGA text controller. It terminates the AXI4-Lite handshakes from the SoC interconnect and turns each transaction into the simple strobe interface that the VGA top level consumes: write data/strobe/address plus a write-ready pulse, and a read request/address plus a combinational read-data return. It sits directly upstream of the VGA top and shares its bus clock.

Parameters:
C_AXI_DATA_WIDTH, 32, AXI-lite data width (only 32 supported)
C_AXI_ADDR_WIDTH, 15, AXI-lite address width
READ_LATENCY, 2, cycles axil_rreq_o/axil_raddr_o are held before axil_rdata_i is sampled (1..7)
WR_PULSE_CYCLES, 2, cycles axil_wready_o stays high per write, so a half-rate consumer always sees it (1..7)

Ports:
clk_i  in  1  bus clock
rst_i  in  1  reset, asynchronous, active-high
s_axil_awvalid_i  in  1  write address valid
s_axil_awready_o  out  1  write address ready
s_axil_awaddr_i  in  C_AXI_ADDR_WIDTH  write byte address
s_axil_wvalid_i  in  1  write data valid
s_axil_wready_o  out  1  write data ready
s_axil_wdata_i  in  C_AXI_DATA_WIDTH  write data
s_axil_wstrb_i  in  C_AXI_DATA_WIDTH/8  write byte strobes
s_axil_bvalid_o  out  1  write response valid
s_axil_bready_i  in  1  write response ready
s_axil_bresp_o  out  2  write response
s_axil_arvalid_i  in  1  read address valid
s_axil_arready_o  out  1  read address ready
s_axil_araddr_i  in  C_AXI_ADDR_WIDTH  read byte address
s_axil_rvalid_o  out  1  read data valid
s_axil_rready_i  in  1  read data ready
s_axil_rdata_o  out  C_AXI_DATA_WIDTH  read data
s_axil_rresp_o  out  2  read response
axil_wdata_o  out  C_AXI_DATA_WIDTH  write data to VGA top
axil_wstrb_o  out  C_AXI_DATA_WIDTH/8  write strobes to VGA top
axil_waddr_o  out  C_AXI_ADDR_WIDTH  write address to VGA top
axil_wready_o  out  1  write commit pulse to VGA top
axil_rreq_o  out  1  read request to VGA top
axil_raddr_o  out  C_AXI_ADDR_WIDTH  read address to VGA top
axil_rdata_i  in  C_AXI_DATA_WIDTH  read data from VGA top (combinational from axil_raddr_o)

Behaviour:
- Reset (rst_i high, async): every output 0; both FSMs idle; AW/W latches empty; counters 0. Reset mid-transaction drops it with no response; the strobe drops immediately.
- Write FSM states: W_IDLE, W_ISSUE, W_RESP.
- W_IDLE: awready_o = !aw_full; wready_o = !w_full. AW and W latch independently in either order or in the same cycle. When both are latched (or complete in the same cycle), go to W_ISSUE on the next edge.
- W_ISSUE: axil_wready_o high for exactly WR_PULSE_CYCLES cycles. axil_waddr_o/wdata_o/wstrb_o stay stable from the first pulse cycle until W_IDLE is re-entered. Then go to W_RESP.
- W_RESP: bvalid_o high, bresp_o = 2'b00 (OKAY), held until bready_i is seen. Then clear the latches and return to W_IDLE. No new AW/W is accepted before that.
- Write latency: AW+W handshaken in cycle 0 -> pulse in cycles 1..WR_PULSE_CYCLES -> bvalid_o in cycle WR_PULSE_CYCLES+1.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
- R_IDLE: arready_o = 1. On handshake, latch araddr and go to R_WAIT.
- R_WAIT: axil_rreq_o = 1 and axil_raddr_o = latched address for READ_LATENCY cycles. On the last cycle, capture axil_rdata_i into the rdata register. Go to R_RESP.
- R_RESP: rvalid_o high; rdata_o/rresp_o (OKAY) held stable until rready_i. Then go to R_IDLE. axil_rreq_o is low in R_IDLE and R_RESP.
- axil_raddr_o holds its last value when idle.
- Read and write FSMs run fully concurrently; no mutual priority.
- Address bits below 2 are passed through unchanged; the downstream block ignores them.
- bready_i/rready_i asserted early (before valid) has no effect. valid/ready combinational loops: none, since all ready outputs are registered-state functions.

Optional Feature:
VGA_AXIL_DECERR_EN
- Defined: a write or read to register space (addr[14:13]=01) with word index addr[4:2] = 7 or addr[12:5] != 0 is not forwarded. No axil_wready_o pulse and no axil_rreq_o. The FSM skips W_ISSUE/R_WAIT, so the response arrives the cycle after the handshake with resp = 2'b10 (SLVERR) and rdata = 0.
- Undefined: all addresses are forwarded and answered OKAY.

Test Plan:
- AW and W in same cycle, addr 0x2004, data 0x0000000A, strb 0xF -> axil_wready_o high in cycles 1-2 with waddr 0x2004 and wdata 0xA; bvalid in cycle 3 with bresp 00.
- W arrives 3 cycles before AW (addr 0x4000) -> wready_o drops after the W handshake; a single 2-cycle pulse follows AW; exactly one response.
- bready_i held low 10 cycles -> bvalid_o and bresp stay stable; new AW is not accepted (awready_o = 0) until the B handshake.
- Read 0x2018 with axil_rdata_i = 0x1 -> axil_rreq_o high in cycles 1-2; rvalid in cycle 3 with rdata 0x1; rready low 5 cycles keeps the data stable.
- Concurrent write to 0x0010 and read from 0x2000 -> both complete with correct data; neither FSM stalls.
- rst_i asserted during W_ISSUE -> axil_wready_o is 0 the same cycle; after release, awready/wready = 1 and no stale bvalid. With VGA_AXIL_DECERR_EN, a write to 0x201C gives bresp 10 with no pulse.

Source files
------------

// File: rtl/vga_axil_slave_if.sv
// AXI4-Lite bus bundle between the SoC interconnect (master) and the VGA front end (slave).
interface vga_axil_slave_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave that converts bus transactions into the VGA top's write-pulse / read-request strobes.
// Optional: define VGA_AXIL_DECERR_EN to answer unmapped register-space accesses with SLVERR.
//
// state   | meaning
// W_IDLE  | collecting AW and W (either order)
// W_ISSUE | axil_wready_o pulse to VGA top
// W_RESP  | bvalid held until bready
// R_IDLE  | accepting AR
// R_WAIT  | axil_rreq_o held while VGA top resolves read data
// R_RESP  | rvalid held until rready
module vga_axil_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int READ_LATENCY     = 2,
  parameter int WR_PULSE_CYCLES  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  vga_axil_slave_if.slave               s_axil,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic                          axil_wready_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t        w_state, w_state_nxt;
  r_state_t        r_state, r_state_nxt;
  logic            aw_full, w_full;
  logic [AW-1:0]   aw_addr;
  logic [DW-1:0]   w_data;
  logic [SW-1:0]   w_strb;
  logic [2:0]      w_cnt, r_cnt;
  logic            w_err, w_err_nxt, r_err, r_err_nxt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            aw_hs, w_hs, ar_hs;
  logic            wr_err_now, rd_err_now;

`ifdef VGA_AXIL_DECERR_EN
  logic [AW-1:0] wr_addr_now;

  // Register space is addr[14:13]=01; only word indices 0..6 of the first block exist.
  function automatic logic addr_err(input logic [AW-1:0] a);
    return (a[14:13] == 2'b01) && ((a[4:2] == 3'b111) || (a[12:5] != 8'd0));
  endfunction

  assign wr_addr_now = aw_full ? aw_addr : s_axil.awaddr;
  assign wr_err_now  = addr_err(wr_addr_now);
  assign rd_err_now  = addr_err(s_axil.araddr);
`else
  assign wr_err_now  = 1'b0;
  assign rd_err_now  = 1'b0;
`endif

  // Ready terms depend only on registered state (gated by reset so outputs read 0 in reset).
  assign s_axil.awready = (w_state == W_IDLE) && !aw_full && !rst_i;
  assign s_axil.wready  = (w_state == W_IDLE) && !w_full && !rst_i;
  assign s_axil.arready = (r_state == R_IDLE) && !rst_i;
  assign aw_hs = s_axil.awvalid && s_axil.awready;
  assign w_hs  = s_axil.wvalid && s_axil.wready;
  assign ar_hs = s_axil.arvalid && s_axil.arready;

  assign s_axil.bvalid = (w_state == W_RESP);
  assign s_axil.bresp  = w_err ? 2'b10 : 2'b00;
  assign s_axil.rvalid = (r_state == R_RESP);
  assign s_axil.rresp  = r_err ? 2'b10 : 2'b00;
  assign s_axil.rdata  = r_data;

  assign axil_wready_o = (w_state == W_ISSUE);
  assign axil_waddr_o  = aw_addr;
  assign axil_wdata_o  = w_data;
  assign axil_wstrb_o  = w_strb;
  assign axil_rreq_o   = (r_state == R_WAIT);
  assign axil_raddr_o  = r_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_err   <= 1'b0;
      r_state <= R_IDLE;
      r_err   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      w_err   <= w_err_nxt;
      r_state <= r_state_nxt;
      r_err   <= r_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    w_err_nxt   = w_err;
    unique case (w_state)
      W_IDLE: begin
        if ((aw_full || aw_hs) && (w_full || w_hs)) begin
          w_err_nxt   = wr_err_now;
          w_state_nxt = wr_err_now ? W_RESP : W_ISSUE;
        end
      end
      W_ISSUE: if (w_cnt == 3'd0) w_state_nxt = W_RESP;
      W_RESP:  if (s_axil.bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    r_err_nxt   = r_err;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_err_nxt   = rd_err_now;
          r_state_nxt = rd_err_now ? R_RESP : R_WAIT;
        end
      end
      R_WAIT:  if (r_cnt == 3'd0) r_state_nxt = R_RESP;
      R_RESP:  if (s_axil.rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= s_axil.awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axil.wdata;
        w_strb <= s_axil.wstrb;
      end
      if (w_state == W_RESP && s_axil.bready) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (w_state != W_ISSUE)  w_cnt <= 3'(WR_PULSE_CYCLES - 1);
      else if (w_cnt != 3'd0)  w_cnt <= w_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (ar_hs) begin
        r_addr <= s_axil.araddr;
        r_data <= '0;
      end
      if (r_state == R_WAIT && r_cnt == 3'd0) r_data <= axil_rdata_i;
      if (r_state != R_WAIT)  r_cnt <= 3'(READ_LATENCY - 1);
      else if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed bench for vga_axil_slave: write/read latency, stalls, concurrency, reset abort, optional SLVERR.
module tb_vga_axil_slave;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] axil_wdata;
   logic [3:0]  axil_wstrb;
   logic [14:0] axil_waddr;
   logic        axil_wready;
   logic        axil_rreq;
   logic [14:0] axil_raddr;
   logic [31:0] axil_rdata;
   logic [31:0] rd_reg_val;
   int          n_chk = 0;
   int          n_err = 0;

   vga_axil_slave_if #(.ADDR_W(15), .DATA_W(32)) bus ();

   vga_axil_slave dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .s_axil        (bus),
      .axil_wdata_o  (axil_wdata),
      .axil_wstrb_o  (axil_wstrb),
      .axil_waddr_o  (axil_waddr),
      .axil_wready_o (axil_wready),
      .axil_rreq_o   (axil_rreq),
      .axil_raddr_o  (axil_raddr),
      .axil_rdata_i  (axil_rdata)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in for the VGA top: one programmable register, everything else returns a tagged address.
   assign axil_rdata = (axil_raddr == 15'h2018) ? rd_reg_val : {16'hA5A5, 1'b0, axil_raddr};

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] o_, input logic [63:0] e_);
      n_chk++;
      if (o_ !== e_) begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o_, e_);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      rd_reg_val = 32'h1;
      bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
      bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
      #2;
      chk("rst_awready", bus.awready, 1'b0);
      chk("rst_wready", bus.wready, 1'b0);
      chk("rst_arready", bus.arready, 1'b0);
      chk("rst_bvalid", bus.bvalid, 1'b0);
      chk("rst_rvalid", bus.rvalid, 1'b0);
      chk("rst_pulse", axil_wready, 1'b0);
      chk("rst_rreq", axil_rreq, 1'b0);
      chk("rst_rdata", bus.rdata, 32'h0);
      tick(); tick();
      rst_i = 1'b0;
      #1;
      chk("idle_awready", bus.awready, 1'b1);
      chk("idle_wready", bus.wready, 1'b1);
      chk("idle_arready", bus.arready, 1'b1);

      // AW and W together
      bus.awvalid = 1; bus.awaddr = 15'h2004;
      bus.wvalid = 1; bus.wdata = 32'h0000000A; bus.wstrb = 4'hF;
      tick();
      bus.awvalid = 0; bus.wvalid = 0;
      chk("t1_pulse_c1", axil_wready, 1'b1);
      chk("t1_waddr", axil_waddr, 15'h2004);
      chk("t1_wdata", axil_wdata, 32'h0000000A);
      chk("t1_wstrb", axil_wstrb, 4'hF);
      chk("t1_bvalid_c1", bus.bvalid, 1'b0);
      tick();
      chk("t1_pulse_c2", axil_wready, 1'b1);
      tick();
      chk("t1_pulse_c3", axil_wready, 1'b0);
      chk("t1_bvalid_c3", bus.bvalid, 1'b1);
      chk("t1_bresp", bus.bresp, 2'b00);
      bus.bready = 1;
      tick();
      bus.bready = 0;
      chk("t1_bvalid_done", bus.bvalid, 1'b0);
      chk("t1_awready_back", bus.awready, 1'b1);

      // W three cycles ahead of AW
      bus.wvalid = 1; bus.wdata = 32'h12345678; bus.wstrb = 4'h3;
      tick();
      bus.wvalid = 0;
      chk("t2_wready_low", bus.wready, 1'b0);
      chk("t2_awready_hi", bus.awready, 1'b1);
      chk("t2_no_pulse_a", axil_wready, 1'b0);
      tick(); tick();
      chk("t2_no_pulse_b", axil_wready, 1'b0);
      bus.awvalid = 1; bus.awaddr = 15'h4000;
      tick();
      bus.awvalid = 0;
      chk("t2_pulse_c1", axil_wready, 1'b1);
      chk("t2_waddr", axil_waddr, 15'h4000);
      chk("t2_wdata", axil_wdata, 32'h12345678);
      chk("t2_wstrb", axil_wstrb, 4'h3);
      tick();
      chk("t2_pulse_c2", axil_wready, 1'b1);
      tick();
      chk("t2_pulse_c3", axil_wready, 1'b0);
      chk("t2_bvalid", bus.bvalid, 1'b1);

      // B stalled 10 cycles while a new AW waits
      bus.awvalid = 1; bus.awaddr = 15'h0124;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_bvalid_hold", bus.bvalid, 1'b1);
         chk("t3_bresp_hold", bus.bresp, 2'b00);
         chk("t3_awready_blocked", bus.awready, 1'b0);
         chk("t3_no_pulse", axil_wready, 1'b0);
      end
      bus.bready = 1;
      tick();
      bus.bready = 0;
      chk("t3_bvalid_done", bus.bvalid, 1'b0);
      chk("t3_awready_open", bus.awready, 1'b1);
      tick();
      bus.awvalid = 0;
      chk("t3_aw_latched", bus.awready, 1'b0);
      chk("t3_w_open", bus.wready, 1'b1);
      chk("t3_no_pulse_yet", axil_wready, 1'b0);
      bus.wvalid = 1; bus.wdata = 32'h00000055; bus.wstrb = 4'hF;
      tick();
      bus.wvalid = 0;
      chk("t3_pulse", axil_wready, 1'b1);
      chk("t3_waddr", axil_waddr, 15'h0124);
      chk("t3_wdata", axil_wdata, 32'h00000055);
      tick(); tick();
      chk("t3_bvalid", bus.bvalid, 1'b1);
      bus.bready = 1;
      tick();
      bus.bready = 0;
      chk("t3_bvalid_end", bus.bvalid, 1'b0);

      // Read with stalled R channel
      bus.arvalid = 1; bus.araddr = 15'h2018;
      tick();
      bus.arvalid = 0;
      chk("t4_rreq_c1", axil_rreq, 1'b1);
      chk("t4_raddr", axil_raddr, 15'h2018);
      chk("t4_arready_low", bus.arready, 1'b0);
      chk("t4_rvalid_c1", bus.rvalid, 1'b0);
      tick();
      chk("t4_rreq_c2", axil_rreq, 1'b1);
      tick();
      chk("t4_rreq_c3", axil_rreq, 1'b0);
      chk("t4_rvalid_c3", bus.rvalid, 1'b1);
      chk("t4_rdata", bus.rdata, 32'h00000001);
      chk("t4_rresp", bus.rresp, 2'b00);
      rd_reg_val = 32'h0000DEAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_rvalid_hold", bus.rvalid, 1'b1);
         chk("t4_rdata_hold", bus.rdata, 32'h00000001);
      end
      chk("t4_raddr_hold", axil_raddr, 15'h2018);
      bus.rready = 1;
      tick();
      bus.rready = 0;
      chk("t4_rvalid_done", bus.rvalid, 1'b0);
      chk("t4_arready_back", bus.arready, 1'b1);

      // Concurrent write and read, responders ready early
      bus.bready = 1; bus.rready = 1;
      bus.awvalid = 1; bus.awaddr = 15'h0010;
      bus.wvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
      bus.arvalid = 1; bus.araddr = 15'h2000;
      tick();
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
      chk("t5_pulse", axil_wready, 1'b1);
      chk("t5_waddr", axil_waddr, 15'h0010);
      chk("t5_wdata", axil_wdata, 32'hCAFEF00D);
      chk("t5_rreq", axil_rreq, 1'b1);
      chk("t5_raddr", axil_raddr, 15'h2000);
      chk("t5_no_early_b", bus.bvalid, 1'b0);
      chk("t5_no_early_r", bus.rvalid, 1'b0);
      tick(); tick();
      chk("t5_bvalid", bus.bvalid, 1'b1);
      chk("t5_rvalid", bus.rvalid, 1'b1);
      chk("t5_rdata", bus.rdata, 32'hA5A52000);
      tick();
      bus.bready = 0; bus.rready = 0;
      chk("t5_b_done", bus.bvalid, 1'b0);
      chk("t5_r_done", bus.rvalid, 1'b0);

      // Reset asserted in the middle of the write pulse
      bus.awvalid = 1; bus.awaddr = 15'h0020;
      bus.wvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'hF;
      tick();
      bus.awvalid = 0; bus.wvalid = 0;
      chk("t6_pulse_pre", axil_wready, 1'b1);
      #1 rst_i = 1'b1;
      #1;
      chk("t6_pulse_dropped", axil_wready, 1'b0);
      chk("t6_awready_rst", bus.awready, 1'b0);
      chk("t6_bvalid_rst", bus.bvalid, 1'b0);
      tick();
      rst_i = 1'b0;
      #1;
      chk("t6_awready_post", bus.awready, 1'b1);
      chk("t6_wready_post", bus.wready, 1'b1);
      tick(); tick(); tick();
      chk("t6_no_stale_b", bus.bvalid, 1'b0);
      chk("t6_no_pulse_post", axil_wready, 1'b0);

      // Write and read to an unmapped register word
      bus.awvalid = 1; bus.awaddr = 15'h201C;
      bus.wvalid = 1; bus.wdata = 32'h77; bus.wstrb = 4'hF;
      tick();
      bus.awvalid = 0; bus.wvalid = 0;
`ifdef VGA_AXIL_DECERR_EN
      chk("t7_no_pulse", axil_wready, 1'b0);
      chk("t7_bvalid", bus.bvalid, 1'b1);
      chk("t7_bresp", bus.bresp, 2'b10);
`else
      chk("t7_pulse", axil_wready, 1'b1);
      chk("t7_waddr", axil_waddr, 15'h201C);
      tick(); tick();
      chk("t7_bvalid", bus.bvalid, 1'b1);
      chk("t7_bresp", bus.bresp, 2'b00);
`endif
      bus.bready = 1;
      tick();
      bus.bready = 0;
      chk("t7_b_done", bus.bvalid, 1'b0);
      bus.arvalid = 1; bus.araddr = 15'h201C;
      tick();
      bus.arvalid = 0;
`ifdef VGA_AXIL_DECERR_EN
      chk("t7_no_rreq", axil_rreq, 1'b0);
      chk("t7_rvalid", bus.rvalid, 1'b1);
      chk("t7_rresp", bus.rresp, 2'b10);
      chk("t7_rdata", bus.rdata, 32'h0);
`else
      chk("t7_rreq", axil_rreq, 1'b1);
      tick(); tick();
      chk("t7_rvalid", bus.rvalid, 1'b1);
      chk("t7_rresp", bus.rresp, 2'b00);
      chk("t7_rdata", bus.rdata, 32'hA5A5201C);
`endif
      bus.rready = 1;
      tick();
      bus.rready = 0;
      chk("t7_r_done", bus.rvalid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
